// File: rtl/memory_access_unit.sv
// MEM stage: load/store alignment, busywait handshake with data memory,
// and the MEM/WB pipeline register that also feeds WB-side forwarding.
module memory_access_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       ex_result,
  input  logic [31:0]       store_data,
  input  logic              mem_read_en,
  input  logic              mem_write_en,
  input  logic [2:0]        func3,
  input  logic [4:0]        reg_write_address_in,
  input  logic              reg_write_en_in,
  input  logic [31:0]       dmem_readdata,
  input  logic              dmem_busywait,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [31:0]       dmem_writedata,
  output logic [3:0]        dmem_byteenable,
  output logic              stall,
  output logic              mem_fault,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_address,
  output logic              wb_write_en
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state_q, state_d;

  // Request captured at the start of a waited access, replayed in ACCESS
  logic              req_read_q, req_write_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [31:0]       req_wdata_q;
  logic [3:0]        req_be_q;
  logic [2:0]        req_func3_q;
  logic [1:0]        req_lane_q;

  logic        is_load, is_store, misaligned, load_f3_bad, store_f3_bad, req_bad;
  logic [1:0]  lane_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic        bad, store_now, load_done;
  logic [2:0]  ext_f3;
  logic [1:0]  ext_lane;
  logic [31:0] shifted, load_value;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Decode of the incoming request; read wins if both enables are set
  assign lane_in      = ex_result[1:0];
  assign is_load      = mem_read_en;
  assign is_store     = mem_write_en & ~mem_read_en;
  assign misaligned   = ((func3[1:0] == 2'b01) & lane_in[0]) |
                        ((func3[1:0] == 2'b10) & (lane_in != 2'b00));
  assign load_f3_bad  = (func3 == 3'b011) | (func3[2:1] == 2'b11);
  assign store_f3_bad = func3[2] | (func3[1:0] == 2'b11);
  assign req_bad      = is_load  ? (load_f3_bad | misaligned) :
                        is_store ? (store_f3_bad | misaligned) : 1'b0;

  // Store lane steering: replicate data, enable only the addressed lanes
  always_comb begin
    be_in    = 4'b0000;
    wdata_in = 32'h0;
    unique case (func3[1:0])
      2'b00: begin
        be_in    = 4'(4'b0001 << lane_in);
        wdata_in = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_in    = 4'(4'b0011 << lane_in);
        wdata_in = {2{store_data[15:0]}};
      end
      2'b10: begin
        be_in    = 4'b1111;
        wdata_in = store_data;
      end
      default: begin
        be_in    = 4'b0000;
        wdata_in = 32'h0;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and memory-side outputs; strobes are forced low during reset
  always_comb begin
    state_d         = state_q;
    dmem_read       = 1'b0;
    dmem_write      = 1'b0;
    dmem_address    = '0;
    dmem_writedata  = 32'h0;
    dmem_byteenable = 4'b0000;
    bad             = 1'b0;
    store_now       = 1'b0;
    ext_f3          = func3;
    ext_lane        = lane_in;
    unique case (state_q)
      IDLE: begin
        bad       = req_bad;
        store_now = is_store;
        if (!req_bad && (is_load || is_store)) begin
          dmem_read       = is_load;
          dmem_write      = is_store;
          dmem_address    = ADDR_W'({ex_result[31:2], 2'b00});
          dmem_writedata  = is_store ? wdata_in : 32'h0;
          dmem_byteenable = is_store ? be_in : 4'b0000;
        end
        if ((dmem_read || dmem_write) && dmem_busywait) state_d = ACCESS;
      end
      ACCESS: begin
        dmem_read       = req_read_q;
        dmem_write      = req_write_q;
        dmem_address    = req_addr_q;
        dmem_writedata  = req_wdata_q;
        dmem_byteenable = req_be_q;
        store_now       = req_write_q;
        ext_f3          = req_func3_q;
        ext_lane        = req_lane_q;
        if (!dmem_busywait) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!RESET) begin
      dmem_read       = 1'b0;
      dmem_write      = 1'b0;
      dmem_byteenable = 4'b0000;
      bad             = 1'b0;
    end
  end

  assign stall     = (dmem_read | dmem_write) & dmem_busywait;
  assign load_done = dmem_read & ~dmem_busywait;

  // Load lane extraction with sign/zero extension
  assign shifted = dmem_readdata >> {ext_lane, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = ext_lane[1] ? dmem_readdata[31:16] : dmem_readdata[15:0];

  always_comb begin
    load_value = dmem_readdata;
    unique case (ext_f3)
      3'b000:  load_value = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_value = {24'h0, byte_v};
      3'b001:  load_value = {{16{half_v[15]}}, half_v};
      3'b101:  load_value = {16'h0, half_v};
      default: load_value = dmem_readdata;
    endcase
  end

  // Capture the request when an access has to wait
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      req_read_q  <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= 32'h0;
      req_be_q    <= 4'b0000;
      req_func3_q <= 3'b000;
      req_lane_q  <= 2'b00;
    end else if (state_q == IDLE && stall) begin
      req_read_q  <= dmem_read;
      req_write_q <= dmem_write;
      req_addr_q  <= dmem_address;
      req_wdata_q <= dmem_writedata;
      req_be_q    <= dmem_byteenable;
      req_func3_q <= func3;
      req_lane_q  <= lane_in;
    end
  end

  // MEM/WB register: bubble while stalled, fault pulse on a bad access
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wb_data     <= 32'h0;
      wb_address  <= 5'd0;
      wb_write_en <= 1'b0;
      mem_fault   <= 1'b0;
    end else begin
      mem_fault <= bad;
      if (stall) begin
        wb_write_en <= 1'b0;
      end else begin
        wb_data     <= load_done ? load_value : ex_result;
        wb_address  <= reg_write_address_in;
        wb_write_en <= reg_write_en_in & ~bad & ~store_now;
      end
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit: stimulus pushes expected memory
// requests and writebacks; a monitor pops and compares as the DUT emits them.
module tb_memory_access_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] ex_result = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        mem_read_en = 1'b0;
  logic        mem_write_en = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [4:0]  reg_write_address_in = 5'd0;
  logic        reg_write_en_in = 1'b0;
  logic [31:0] dmem_readdata = 32'h0;
  logic        dmem_busywait = 1'b0;
  logic        dmem_read, dmem_write, stall, mem_fault, wb_write_en;
  logic [31:0] dmem_address, dmem_writedata, wb_data;
  logic [3:0]  dmem_byteenable;
  logic [4:0]  wb_address;

  memory_access_unit #(.ADDR_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .ex_result(ex_result), .store_data(store_data),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .func3(func3),
    .reg_write_address_in(reg_write_address_in), .reg_write_en_in(reg_write_en_in),
    .dmem_readdata(dmem_readdata), .dmem_busywait(dmem_busywait),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_writedata(dmem_writedata), .dmem_byteenable(dmem_byteenable),
    .stall(stall), .mem_fault(mem_fault), .wb_data(wb_data),
    .wb_address(wb_address), .wb_write_en(wb_write_en)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mreq_t;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wb_t;

  mreq_t mq[$];
  wb_t   wq[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] rdst, input logic we);
    mem_read_en          = rd;
    mem_write_en         = wr;
    func3                = f3;
    ex_result            = addr;
    store_data           = data;
    reg_write_address_in = rdst;
    reg_write_en_in      = we;
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: a strobe with busywait low completes at the next edge; a high
  // wb_write_en is a writeback. Each is matched against its queue.
  initial begin : monitor
    mreq_t me;
    wb_t   we;
    forever begin
      @(negedge CLK);
      if (RESET && (dmem_read || dmem_write) && !dmem_busywait) begin
        if (mq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_req: unexpected request addr %h rd %b wr %b",
                   dmem_address, dmem_read, dmem_write);
        end else begin
          me = mq.pop_front();
          chk("mem_rd", 32'(dmem_read), 32'(me.rd));
          chk("mem_wr", 32'(dmem_write), 32'(me.wr));
          chk("mem_addr", dmem_address, me.addr);
          chk("mem_be", 32'(dmem_byteenable), 32'(me.be));
          if (me.wr) chk("mem_wdata", dmem_writedata, me.wdata);
        end
      end
      if (wb_write_en) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb: unexpected write rd %0d data %h", wb_address, wb_data);
        end else begin
          we = wq.pop_front();
          chk("wb_address", 32'(wb_address), 32'(we.a));
          chk("wb_data", wb_data, we.d);
        end
      end
    end
  end

  initial begin : stim
    // Reset state
    @(negedge CLK);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_address", 32'(wb_address), 32'h0);
    chk("rst_wb_write_en", 32'(wb_write_en), 32'h0);
    chk("rst_mem_fault", 32'(mem_fault), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_strobes", 32'({dmem_read, dmem_write}), 32'h0);
    chk("rst_be", 32'(dmem_byteenable), 32'h0);
    next_cycle();
    RESET = 1'b1;

    // Pass-through of a non-memory result
    issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    wq.push_back('{a: 5'd5, d: 32'h0000_1234});
    @(negedge CLK);
    chk("pt_stall", 32'(stall), 32'h0);
    next_cycle();
    idle();
    @(negedge CLK);
    chk("pt_stall2", 32'(stall), 32'h0);
    next_cycle();

    // Zero-wait loads: LB, LBU, LH, LHU
    dmem_readdata = 32'h80FF_0000;
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd6, 1'b1);
    mq.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'b0000});
    wq.push_back('{a: 5'd6, d: 32'hFFFF_FF80});
    @(negedge CLK);
    chk("lb_stall", 32'(stall), 32'h0);
    next_cycle();
    issue(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd7, 1'b1);
    mq.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'b0000});
    wq.push_back('{a: 5'd7, d: 32'h0000_0080});
    next_cycle();
    dmem_readdata = 32'h8001_0000;
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd11, 1'b1);
    mq.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'b0000});
    wq.push_back('{a: 5'd11, d: 32'hFFFF_8001});
    next_cycle();
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd12, 1'b1);
    mq.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'b0000});
    wq.push_back('{a: 5'd12, d: 32'h0000_8001});
    next_cycle();

    // Zero-wait stores: SB and SW never write back
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h1122_33AB, 5'd13, 1'b1);
    mq.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'h100, wdata: 32'hABAB_ABAB, be: 4'b0010});
    next_cycle();
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 5'd13, 1'b1);
    mq.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'h010, wdata: 32'hCAFE_F00D, be: 4'b1111});
    next_cycle();
    idle();
    next_cycle();

    // SH with two wait states
    dmem_busywait = 1'b1;
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hABCD_1234, 5'd14, 1'b1);
    mq.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'h200, wdata: 32'h1234_1234, be: 4'b1100});
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("sh_stall", 32'(stall), 32'h1);
      chk("sh_write_held", 32'(dmem_write), 32'h1);
      chk("sh_addr_held", dmem_address, 32'h200);
      chk("sh_be_held", 32'(dmem_byteenable), 32'hC);
      chk("sh_wdata_held", dmem_writedata, 32'h1234_1234);
      next_cycle();
    end
    dmem_busywait = 1'b0;
    @(negedge CLK);
    chk("sh_stall_done", 32'(stall), 32'h0);
    next_cycle();
    idle();
    @(negedge CLK);
    chk("sh_no_wb", 32'(wb_write_en), 32'h0);
    next_cycle();

    // LW with three wait states
    dmem_busywait = 1'b1;
    dmem_readdata = 32'h0;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("lw_stall", 32'(stall), 32'h1);
      chk("lw_bubble", 32'(wb_write_en), 32'h0);
      next_cycle();
    end
    dmem_busywait = 1'b0;
    dmem_readdata = 32'hDEAD_BEEF;
    mq.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h300, wdata: 32'h0, be: 4'b0000});
    wq.push_back('{a: 5'd8, d: 32'hDEAD_BEEF});
    @(negedge CLK);
    chk("lw_stall_done", 32'(stall), 32'h0);
    next_cycle();
    idle();
    next_cycle();

    // Misaligned LW: no strobe, no stall, one-cycle fault
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 5'd9, 1'b1);
    @(negedge CLK);
    chk("mis_no_read", 32'(dmem_read), 32'h0);
    chk("mis_stall", 32'(stall), 32'h0);
    next_cycle();
    idle();
    @(negedge CLK);
    chk("mis_fault", 32'(mem_fault), 32'h1);
    chk("mis_no_wb", 32'(wb_write_en), 32'h0);
    next_cycle();
    @(negedge CLK);
    chk("mis_fault_pulse", 32'(mem_fault), 32'h0);
    next_cycle();

    // Illegal store width code
    issue(1'b0, 1'b1, 3'b011, 32'h0000_0020, 32'h5555_5555, 5'd3, 1'b1);
    @(negedge CLK);
    chk("ill_no_write", 32'(dmem_write), 32'h0);
    next_cycle();
    idle();
    @(negedge CLK);
    chk("ill_fault", 32'(mem_fault), 32'h1);
    next_cycle();

    // Reset asserted mid-access drops strobe and stall at once
    dmem_busywait = 1'b1;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd9, 1'b1);
    @(negedge CLK);
    chk("ra_stall", 32'(stall), 32'h1);
    next_cycle();
    #2;
    RESET = 1'b0;
    #1;
    chk("ra_read_drop", 32'(dmem_read), 32'h0);
    chk("ra_stall_drop", 32'(stall), 32'h0);
    chk("ra_wb_we", 32'(wb_write_en), 32'h0);
    idle();
    dmem_busywait = 1'b0;
    next_cycle();
    RESET = 1'b1;

    // Fresh LW after reset release
    dmem_readdata = 32'h1234_5678;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd10, 1'b1);
    mq.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h040, wdata: 32'h0, be: 4'b0000});
    wq.push_back('{a: 5'd10, d: 32'h1234_5678});
    next_cycle();
    idle();
    next_cycle();
    next_cycle();

    chk("mem_queue_drained", 32'(mq.size()), 32'h0);
    chk("wb_queue_drained", 32'(wq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
